// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory hierarchy: access-mode encoding,
// cache controller states and line geometry.
package mem_pkg;

  typedef enum logic [2:0] {
    MODE_NONE = 3'b000,
    MODE_W    = 3'b001,
    MODE_H    = 3'b010,
    MODE_B    = 3'b011,
    MODE_HU   = 3'b100,
    MODE_BU   = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STORE,
    S_RESP
  } state_e;

  localparam int WORD_W          = 32;
  localparam int LINE_INDEX_BITS = 8;

  // Tag width for a one-word-per-line cache addressed by byte address.
  function automatic int tag_width(input int width, input int index_bits);
    return width - 2 - index_bits;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the big-endian half/byte of a word and sign/zero-extends it
// according to the modeBU access encoding.
module load_extend
  import mem_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [2:0]       i_mode,
  output logic [WIDTH-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (mode_e'(i_mode))
      MODE_W:  o_result = i_word;
      MODE_H:  o_result = {{(WIDTH-16){i_word[WIDTH-1]}}, i_word[WIDTH-1 -: 16]};
      MODE_HU: o_result = {{(WIDTH-16){1'b0}}, i_word[WIDTH-1 -: 16]};
      MODE_B:  o_result = {{(WIDTH-8){i_word[WIDTH-1]}}, i_word[WIDTH-1 -: 8]};
      MODE_BU: o_result = {{(WIDTH-8){1'b0}}, i_word[WIDTH-1 -: 8]};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, one-word-per-line data cache. Loads hit in the
// same cycle; load misses and all stores stall the core for a memory handshake.
module data_cache
  import mem_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter int INDEX_BITS = LINE_INDEX_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic [2:0]       cpu_modeBU,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [2:0]       mem_modeBU,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int TAG_W = tag_width(WIDTH, INDEX_BITS);
  localparam int LINES = 1 << INDEX_BITS;

  state_e                r_state;
  state_e                w_next;
  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [WIDTH-1:0]      r_data [LINES];

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic [WIDTH-1:0]      w_line;
  logic [WIDTH-1:0]      w_ext;
  logic                  w_rd_en;
  logic                  w_fill_wr;
  logic                  w_store_wr;
  logic                  w_hit_inc;
  logic                  w_miss_inc;
  logic                  w_unused_addr;

  // Big-endian partial-store merge: the written bytes land in the top of the word.
  function automatic logic [WIDTH-1:0] merge_store(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [2:0]       mode);
    case (mode_e'(mode))
      MODE_W:          return new_w;
      MODE_H, MODE_HU: return {new_w[15:0], old_w[WIDTH-17:0]};
      MODE_B, MODE_BU: return {new_w[7:0], old_w[WIDTH-9:0]};
      default:         return old_w;
    endcase
  endfunction

  assign w_idx         = cpu_addr[INDEX_BITS+1:2];
  assign w_tag         = cpu_addr[WIDTH-1:INDEX_BITS+2];
  assign w_line        = r_data[w_idx];
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused_addr = &{1'b0, cpu_addr[1:0]};

  always_comb begin
    w_next     = r_state;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_modeBU = 3'b000;
    w_rd_en    = 1'b0;
    w_fill_wr  = 1'b0;
    w_store_wr = 1'b0;
    w_hit_inc  = 1'b0;
    w_miss_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_re) begin
          if (w_hit) begin
            w_rd_en   = 1'b1;
            w_hit_inc = 1'b1;
          end else begin
            stall      = 1'b1;
            w_miss_inc = 1'b1;
            w_next     = S_FILL;
          end
        end else if (cpu_we) begin
          stall  = 1'b1;
          w_next = S_STORE;
        end
      end
      S_FILL: begin
        stall      = 1'b1;
        mem_req    = 1'b1;
        mem_addr   = {cpu_addr[WIDTH-1:2], 2'b00};
        mem_modeBU = MODE_W;
        if (mem_ack) begin
          w_fill_wr = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_STORE: begin
        stall      = 1'b1;
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {cpu_addr[WIDTH-1:2], 2'b00};
        mem_wdata  = cpu_wdata;
        mem_modeBU = cpu_modeBU;
        if (mem_ack) begin
          w_store_wr = w_hit;
          w_next     = S_RESP;
        end
      end
      S_RESP: begin
        w_rd_en = cpu_re;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .i_word   (w_line),
    .i_mode   (cpu_modeBU),
    .o_result (w_ext)
  );

  assign cpu_rdata = w_rd_en ? w_ext : '0;

  // Control state: FSM, valid bits and counters clear asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_fill_wr) r_valid[w_idx] <= 1'b1;
      if (w_hit_inc) hit_count <= hit_count + 32'd1;
      if (w_miss_inc) miss_count <= miss_count + 32'd1;
    end
  end

  // Line storage: tag and data need no reset, validity is tracked above.
  always_ff @(posedge clk) begin
    if (w_fill_wr) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_rdata;
    end else if (w_store_wr) begin
      r_data[w_idx] <= merge_store(w_line, cpu_wdata, cpu_modeBU);
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed scoreboard bench for data_cache: loads push expected data into a
// queue, a monitor pops and compares whenever the cache returns load data.
module tb_data_cache;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_modeBU;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_modeBU;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count, miss_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  logic [31:0] tb_mem [logic [31:0]];
  logic        mem_en    = 1'b1;
  logic        force_ack = 1'b0;
  logic        last_we;
  logic [2:0]  last_mode;
  logic [31:0] last_addr, last_wdata;

  data_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_re     (cpu_re),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_modeBU (cpu_modeBU),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_modeBU (mem_modeBU),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                            input logic [2:0] mode);
    case (mode)
      3'b001:         return wd;
      3'b010, 3'b100: return {wd[15:0], old_w[15:0]};
      3'b011, 3'b101: return {wd[7:0], old_w[23:0]};
      default:        return old_w;
    endcase
  endfunction

  // Backing memory: acks the MEM_LAT-th cycle that mem_req is seen high.
  initial begin
    int cnt;
    logic [31:0] old_w;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (force_ack) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_en && mem_req) begin
        cnt++;
        if (cnt >= MEM_LAT) begin
          last_we    = mem_we;
          last_mode  = mem_modeBU;
          last_addr  = mem_addr;
          last_wdata = mem_wdata;
          old_w = tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : 32'h0;
          if (mem_we) tb_mem[mem_addr] = mem_merge(old_w, mem_wdata, mem_modeBU);
          else mem_rdata = old_w;
          mem_ack = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: a load completes on any cycle with cpu_re high and stall low.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && cpu_re && !stall) begin
        if (exp_q.size() == 0) begin
          check("unexpected_load_rdata", cpu_rdata, 32'hxxxxxxxx);
        end else begin
          exp = exp_q.pop_front();
          check("load_rdata", cpu_rdata, exp);
        end
      end
    end
  end

  task automatic wait_done(input string name, input int exp_stall);
    int n;
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        break;
      end
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: stall still high after %0d cycles, required release", name, n);
    end
    check({name, "_stall_cycles"}, n, exp_stall);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] mode,
                         input logic [31:0] exp, input int exp_stall);
    exp_q.push_back(exp);
    cpu_addr = addr;
    cpu_modeBU = mode;
    cpu_re = 1'b1;
    wait_done("load", exp_stall);
    @(posedge clk);
    #2;
    cpu_re = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [2:0] mode,
                          input logic [31:0] wdata, input int exp_stall);
    cpu_addr = addr;
    cpu_modeBU = mode;
    cpu_wdata = wdata;
    cpu_we = 1'b1;
    wait_done("store", exp_stall);
    @(posedge clk);
    #2;
    cpu_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_mem[32'h100] = 32'hDEADBEEF;
    tb_mem[32'h104] = 32'h80F01234;
    tb_mem[32'h108] = 32'h11223344;
    tb_mem[32'h200] = 32'hCAFEF00D;
    tb_mem[32'h004] = 32'h01020304;
    tb_mem[32'h404] = 32'h0A0B0C0D;
    tb_mem[32'h300] = 32'h55667788;
    rst_n = 1'b0;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_modeBU = 3'b001;
    #12;
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_hit_count", hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Cold miss, then hit
    do_load(32'h100, 3'b001, 32'hDEADBEEF, 4);
    check("fill_mem_we", {31'b0, last_we}, 32'h0);
    check("fill_mem_mode", {29'b0, last_mode}, 32'h1);
    check("fill_mem_addr", last_addr, 32'h100);
    do_load(32'h100, 3'b001, 32'hDEADBEEF, 0);
    check("hit_count_1", hit_count, 32'd1);
    check("miss_count_1", miss_count, 32'd1);

    // Extension on a hit line
    do_load(32'h104, 3'b001, 32'h80F01234, 4);
    do_load(32'h104, 3'b010, 32'hFFFF80F0, 0);
    do_load(32'h104, 3'b100, 32'h000080F0, 0);
    do_load(32'h104, 3'b011, 32'hFFFFFF80, 0);
    do_load(32'h104, 3'b101, 32'h00000080, 0);
    do_load(32'h104, 3'b000, 32'h00000000, 0);
    do_load(32'h106, 3'b110, 32'h00000000, 0);
    check("hit_count_2", hit_count, 32'd7);
    check("miss_count_2", miss_count, 32'd2);

    // Store hit merges
    do_load(32'h108, 3'b001, 32'h11223344, 4);
    do_store(32'h108, 3'b011, 32'h000000AB, 4);
    check("store_mem_we", {31'b0, last_we}, 32'h1);
    check("store_mem_mode", {29'b0, last_mode}, 32'h3);
    check("store_mem_addr", last_addr, 32'h108);
    check("store_mem_wdata", last_wdata, 32'h000000AB);
    do_load(32'h108, 3'b001, 32'hAB223344, 0);
    do_store(32'h105, 3'b010, 32'h0000BEEF, 4);
    check("store_half_mem_addr", last_addr, 32'h104);
    do_load(32'h104, 3'b001, 32'hBEEF1234, 0);
    check("hit_count_3", hit_count, 32'd9);
    check("miss_count_3", miss_count, 32'd3);

    // Store miss does not allocate
    do_store(32'h200, 3'b001, 32'h12345678, 4);
    check("store_miss_mem_we", {31'b0, last_we}, 32'h1);
    check("store_miss_mem_wdata", last_wdata, 32'h12345678);
    do_load(32'h200, 3'b001, 32'h12345678, 4);
    check("miss_count_4", miss_count, 32'd4);

    // Index aliasing
    do_load(32'h004, 3'b001, 32'h01020304, 4);
    do_load(32'h404, 3'b001, 32'h0A0B0C0D, 4);
    do_load(32'h004, 3'b001, 32'h01020304, 4);
    check("hit_count_5", hit_count, 32'd9);
    check("miss_count_5", miss_count, 32'd7);

    // Reset during FILL
    mem_en = 1'b0;
    cpu_addr = 32'h300;
    cpu_modeBU = 3'b001;
    cpu_re = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("fill_mem_req_high", {31'b0, mem_req}, 32'h1);
    check("fill_stall_high", {31'b0, stall}, 32'h1);
    #1;
    cpu_re = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("async_rst_stall", {31'b0, stall}, 32'h0);
    check("async_rst_hit_count", hit_count, 32'h0);
    check("async_rst_miss_count", miss_count, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    force_ack = 1'b1;
    @(posedge clk);
    #2;
    force_ack = 1'b0;
    @(posedge clk);
    #2;
    check("late_ack_mem_req", {31'b0, mem_req}, 32'h0);
    check("late_ack_stall", {31'b0, stall}, 32'h0);
    check("late_ack_miss_count", miss_count, 32'h0);
    mem_en = 1'b1;
    do_load(32'h300, 3'b001, 32'h55667788, 4);
    check("post_rst_hit_count", hit_count, 32'd0);
    check("post_rst_miss_count", miss_count, 32'd1);

    @(posedge clk);
    #2;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, one-word-per-line data cache between the core's memory stage and `data_memory`. It serves loads on hit in the same cycle. On a load miss, or on any store, it stalls the core and runs a handshake with the backing memory. It keeps the memory's big-endian byte layout and its `modeBU` access encoding, so the data the core sees is identical with or without the cache.

## Interface
Parameters:
- `WIDTH`, 32: data/address width.
- `INDEX_BITS`, 8: log2 of the line count (256 lines); tag = `WIDTH-2-INDEX_BITS` bits.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cpu_re`  in  1: load request.
- `cpu_we`  in  1: store request. `cpu_re`/`cpu_we` are never both high.
- `cpu_addr`  in  WIDTH: byte address. Bits [1:0] are ignored, as in the backing memory.
- `cpu_wdata`  in  WIDTH: store data.
- `cpu_modeBU`  in  3: 001 word, 010 half, 011 byte, 100 half unsigned, 101 byte unsigned.
- `cpu_rdata`  out  WIDTH: load result, sign/zero-extended.
- `stall`  out  1: core must hold its request and PC.
- `mem_req`  out  1: backing-memory request, held until `mem_ack`.
- `mem_we`  out  1: request is a store.
- `mem_addr`  out  WIDTH: `{cpu_addr[WIDTH-1:2],2'b00}`.
- `mem_wdata`  out  WIDTH: copy of `cpu_wdata`.
- `mem_modeBU`  out  3: copy of `cpu_modeBU` for stores; 001 for fills.
- `mem_rdata`  in  WIDTH: full big-endian word. Valid in the `mem_ack` cycle.
- `mem_ack`  in  1: one-cycle completion pulse, at least 1 cycle after `mem_req` rises.
- `hit_count`, `miss_count`  out  32: load hit and load miss counters, wrapping.

## Operation
- Storage per line: valid bit, tag, 32-bit word.
- Hit condition: `valid[idx] && tag[idx]==cpu_addr[WIDTH-1:INDEX_BITS+2]`, with `idx = cpu_addr[INDEX_BITS+1:2]`.
- Byte layout: byte 0 of a word is bits [31:24].
  - Half access uses bits [31:16]; byte access uses bits [31:24].
  - Extension follows `modeBU`. Encodings 000, 110 and 111 return 0.
- FSM states: IDLE, FILL, STORE, RESP.
  - IDLE, load hit: `stall`=0, `cpu_rdata` from the line, `hit_count`++ at the edge.
  - IDLE, load miss: `stall`=1 combinationally, `miss_count`++, go to FILL.
  - IDLE, store: `stall`=1, go to STORE.
  - FILL: `mem_req`=1, `mem_we`=0. On `mem_ack`, write the line (valid=1, tag, `mem_rdata`) and go to RESP.
  - STORE: `mem_req`=1, `mem_we`=1. On `mem_ack`, if the line hits, merge the write; then go to RESP. A store miss does not allocate.
  - RESP: `stall`=0, `cpu_rdata` from the line (loads), counters unchanged. Next state is IDLE unconditionally.
- Store merge into a hit line:
  - word: replaces all 32 bits.
  - half (010/100): `cpu_wdata[15:0]` goes to [31:16].
  - byte (011/101): `cpu_wdata[7:0]` goes to [31:24].
- `mem_*` outputs other than `mem_req` are don't-care when `mem_req`=0; drive them 0.

## Timing
- Reset values: state IDLE, all valid bits 0, `mem_req`/`mem_we` 0, counters 0.
  - With no request, `stall`=0 and `cpu_rdata`=0.
- Load hit latency: 0 cycles (combinational).
- Load miss latency: `stall` high from the request cycle until the `mem_ack` edge, then one RESP cycle with `stall`=0.
  - Total = memory latency + 2 cycles.
- Store latency: same as a load miss. The write is globally visible when `mem_ack` is sampled.
- `mem_req` stays high with stable address/data from entry to FILL or STORE until the cycle `mem_ack`=1, and drops the following cycle.
- `mem_ack` in IDLE or RESP is ignored.
- Reset mid-FILL/STORE: `mem_req` drops asynchronously, no line is written, and the state returns to IDLE.
- Wrap-around: the counters roll from 0xFFFFFFFF to 0.
- Index aliasing: a fill overwrites a valid line with a different tag; there is no victim writeback because the cache is write-through.

## Structure
- Shared package `mem_pkg`:
  - `modeBU` enum: `MODE_W`=001, `MODE_H`, `MODE_B`, `MODE_HU`, `MODE_BU`.
  - FSM state enum.
  - Line/tag width localparams.
- Sub-module `load_extend`: combinational word + `modeBU` to extended result. The same function is needed by `data_memory` later.
- Line arrays live in `data_cache`, with valid bits in flops so they can be reset asynchronously.

## Test plan
- Cold load: load 0x100, mode 001, memory word 0xDEADBEEF, ack after 3 cycles.
  - `stall`=1 for 4 cycles, then RESP with `cpu_rdata`=0xDEADBEEF.
  - Repeat load of 0x100: 0-cycle hit; `hit_count`=1, `miss_count`=1.
- Extension on a hit line 0x80F0_1234:
  - mode 010 returns 0xFFFF80F0; mode 100 returns 0x000080F0.
  - mode 011 returns 0xFFFFFF80; mode 101 returns 0x00000080.
- Store hit merge: line 0x11223344, store byte (011) with `cpu_wdata`=0x000000AB.
  - Memory sees `mem_we`=1, `mem_modeBU`=011.
  - Subsequent word load hits with 0xAB223344.
- Store miss: store word to uncached 0x200.
  - `mem_req` issued; line stays invalid.
  - Next load of 0x200 misses and fills.
- Aliasing: load 0x0004, then load `0x0004 + 2^(INDEX_BITS+2)`.
  - Second load misses; third access to 0x0004 misses again.
- Reset: assert `rst_n`=0 during FILL before `mem_ack`.
  - `mem_req` drops immediately, a late ack is ignored, the counters are 0 and the next load of that address misses.
